pipe_run_ctrl: RTL and testbench

PIPE_RUN_CTRL -- requirements
Module: pipe_run_ctrl

---
 rtl/pipe_run_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_run_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_run_ctrl.sv
// Run/step/drain controller for a 5-stage pipeline: turns debugger commands into
// pipeline-enable, program-reset and report pulses; every output is registered.
module pipe_run_ctrl #(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd,
    output logic             o_cmd_ready,
    input  logic             i_halt_seen,
    input  logic             i_load_busy,
    output logic             o_pipe_en,
    output logic             o_prog_reset,
    output logic             o_report_req,
    output logic             o_done,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_count
);

    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

    localparam logic [1:0] CMD_PRST = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_HALT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4,
        S_DONE   = 3'd5,
        S_PRST   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              pipe_en_q, pipe_en_d;
    logic              prog_reset_q, prog_reset_d;
    logic              report_q, report_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic cmd_acc;
    assign cmd_acc = i_cmd_valid & ready_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            drain_q      <= '0;
            pipe_en_q    <= 1'b0;
            prog_reset_q <= 1'b0;
            report_q     <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            pipe_en_q    <= pipe_en_d;
            prog_reset_q <= prog_reset_d;
            report_q     <= report_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        report_d = 1'b0;
        done_d   = done_q;
        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (cmd_acc) begin
                    unique case (i_cmd)
                        CMD_PRST: state_d = S_PRST;
                        CMD_RUN:  state_d = S_RUN;
                        CMD_STEP: state_d = S_STEP;
                        default:  state_d = state_q;
                    endcase
                end
            end
            S_RUN: begin
                // Program reset beats a halt opcode, which beats a debugger HALT.
                if (cmd_acc && i_cmd == CMD_PRST) begin
                    state_d = S_PRST;
                end else if (pipe_en_q && i_halt_seen) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (cmd_acc && i_cmd == CMD_HALT) begin
                    state_d  = S_HALTED;
                    report_d = 1'b1;
                end
            end
            S_STEP: begin
                // pipe_en_q high marks the single step cycle just issued.
                if (pipe_en_q) begin
                    if (i_halt_seen) begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        state_d  = S_HALTED;
                        report_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q <= DW'(1)) begin
                    state_d  = S_DONE;
                    drain_d  = '0;
                    done_d   = 1'b1;
                    report_d = 1'b1;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            S_DONE: begin
                if (cmd_acc && i_cmd == CMD_PRST) begin
                    state_d = S_PRST;
                end
            end
            S_PRST: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                drain_d = '0;
            end
        endcase
        if (state_d == S_PRST) begin
            done_d = 1'b0;
        end
    end

    always_comb begin
        pipe_en_d    = 1'b0;
        prog_reset_d = (state_d == S_PRST);
        ready_d      = 1'b0;
        unique case (state_d)
            S_RUN, S_STEP: pipe_en_d = ~i_load_busy;
            S_DRAIN:       pipe_en_d = (drain_d != '0);
            default:       pipe_en_d = 1'b0;
        endcase
        if (state_d == S_IDLE || state_d == S_RUN || state_d == S_HALTED || state_d == S_DONE) begin
            ready_d = ~i_load_busy;
        end
        if (state_d == S_PRST) begin
            cnt_d = '0;
        end else if (pipe_en_d && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign o_cmd_ready   = ready_q;
    assign o_pipe_en     = pipe_en_q;
    assign o_prog_reset  = prog_reset_q;
    assign o_report_req  = report_q;
    assign o_done        = done_q;
    assign o_state       = state_q;
    assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl: run, load stall, saturation, halt, step,
// drain, program reset, priorities and reset mid-drain.
module tb_pipe_run_ctrl;

    localparam int CNT_W = 4;
    localparam int DRAIN_CYCLES = 4;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_cmd_valid = 1'b0;
    logic [1:0]       i_cmd = 2'b00;
    logic             o_cmd_ready;
    logic             i_halt_seen = 1'b0;
    logic             i_load_busy = 1'b0;
    logic             o_pipe_en;
    logic             o_prog_reset;
    logic             o_report_req;
    logic             o_done;
    logic [2:0]       o_state;
    logic [CNT_W-1:0] o_cycle_count;

    int errors = 0;
    int checks = 0;

    pipe_run_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
        .o_cmd_ready(o_cmd_ready), .i_halt_seen(i_halt_seen), .i_load_busy(i_load_busy),
        .o_pipe_en(o_pipe_en), .o_prog_reset(o_prog_reset), .o_report_req(o_report_req),
        .o_done(o_done), .o_state(o_state), .o_cycle_count(o_cycle_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] c);
        i_cmd_valid = 1'b1;
        i_cmd = c;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    int pe_n;
    int rep_n;

    initial begin
        // reset
        tick(); tick();
        check("rst_state", o_state, 0);
        check("rst_pipe_en", o_pipe_en, 0);
        check("rst_count", o_cycle_count, 0);
        check("rst_done", o_done, 0);
        check("rst_prog_reset", o_prog_reset, 0);
        check("rst_report", o_report_req, 0);
        i_rst = 1'b0;
        tick();
        check("idle_ready", o_cmd_ready, 1);

        // RUN for 10 enabled cycles
        cmd(2'b01);
        check("run_state", o_state, 1);
        check("run_pipe_en_first", o_pipe_en, 1);
        pe_n = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            pe_n += o_pipe_en;
        end
        check("run_pe_cycles", pe_n, 10);
        check("run_count10", o_cycle_count, 10);
        check("run_state10", o_state, 1);

        // load busy for 5 cycles freezes the pipeline
        i_load_busy = 1'b1;
        pe_n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            pe_n += o_pipe_en;
            check("busy_ready", o_cmd_ready, 0);
        end
        i_load_busy = 1'b0;
        check("busy_pe_cycles", pe_n, 0);
        check("busy_count_frozen", o_cycle_count, 10);
        tick();
        check("busy_resume_pe", o_pipe_en, 1);
        check("busy_resume_count", o_cycle_count, 11);
        check("busy_resume_ready", o_cmd_ready, 1);

        // counter saturates at all-ones
        repeat (6) tick();
        check("count_saturate", o_cycle_count, 15);

        // HALT from RUN
        cmd(2'b11);
        check("halt_state", o_state, 4);
        check("halt_report", o_report_req, 1);
        check("halt_pipe_en", o_pipe_en, 0);
        tick();
        check("halt_report_pulse", o_report_req, 0);

        // PROG_RESET from HALTED
        cmd(2'b00);
        check("prst_state", o_state, 6);
        check("prst_pulse", o_prog_reset, 1);
        check("prst_pipe_en", o_pipe_en, 0);
        check("prst_count", o_cycle_count, 0);
        tick();
        check("prst_to_idle", o_state, 0);
        check("prst_pulse_end", o_prog_reset, 0);

        // RUN one cycle, HALT, then 3 single steps
        cmd(2'b01);
        check("run2_count", o_cycle_count, 1);
        cmd(2'b11);
        check("run2_halted", o_state, 4);
        rep_n = 0;
        for (int s = 0; s < 3; s++) begin
            cmd(2'b10);
            check("step_state", o_state, 2);
            check("step_pipe_en", o_pipe_en, 1);
            tick();
            check("step_back_halted", o_state, 4);
            check("step_pipe_en_off", o_pipe_en, 0);
            rep_n += o_report_req;
        end
        check("step_reports", rep_n, 3);
        check("step_count", o_cycle_count, 4);

        // RUN then halt opcode -> drain 4 cycles -> DONE
        cmd(2'b01);
        check("run3_count", o_cycle_count, 5);
        i_halt_seen = 1'b1;
        tick();
        i_halt_seen = 1'b0;
        check("drain_entered", o_state, 3);
        pe_n = o_pipe_en;
        rep_n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pe_n += o_pipe_en;
            rep_n += o_report_req;
        end
        check("drain_pe_cycles", pe_n, 4);
        check("drain_reports", rep_n, 1);
        check("done_state", o_state, 5);
        check("done_flag", o_done, 1);
        check("done_count", o_cycle_count, 9);
        cmd(2'b01);
        check("done_ignores_run", o_state, 5);
        check("done_pipe_en", o_pipe_en, 0);

        // PROG_RESET from DONE
        cmd(2'b00);
        check("prst2_pulse", o_prog_reset, 1);
        check("prst2_done_clr", o_done, 0);
        check("prst2_count", o_cycle_count, 0);
        tick();
        check("prst2_idle", o_state, 0);
        check("prst2_pulse_once", o_prog_reset, 0);

        // HALT and halt opcode together -> DRAIN, then reset at counter 2
        cmd(2'b01);
        i_halt_seen = 1'b1;
        cmd(2'b11);
        i_halt_seen = 1'b0;
        check("tie_drain", o_state, 3);
        check("tie_no_report", o_report_req, 0);
        tick(); tick();
        i_rst = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd = 2'b01;
        tick();
        check("rst_drain_state", o_state, 0);
        check("rst_drain_pe", o_pipe_en, 0);
        check("rst_drain_count", o_cycle_count, 0);
        check("rst_drain_done", o_done, 0);
        i_cmd_valid = 1'b0;
        i_rst = 1'b0;
        tick();
        check("rst_cmd_discarded", o_state, 0);

        // PROG_RESET beats halt opcode in RUN; halt opcode ignored in IDLE
        cmd(2'b01);
        i_halt_seen = 1'b1;
        cmd(2'b00);
        check("prst_priority", o_state, 6);
        tick();
        tick();
        check("idle_ignores_halt_seen", o_state, 0);
        i_halt_seen = 1'b0;

        // STEP waits while the loader is busy
        i_load_busy = 1'b1;
        cmd(2'b10);
        check("step_busy_state", o_state, 2);
        check("step_busy_pe", o_pipe_en, 0);
        tick();
        check("step_busy_wait", o_pipe_en, 0);
        i_load_busy = 1'b0;
        tick();
        check("step_release_pe", o_pipe_en, 1);
        tick();
        check("step_release_halted", o_state, 4);
        check("step_release_report", o_report_req, 1);
        check("step_release_count", o_cycle_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
